// File: rtl/delay_ring_pkg.sv
// delay_ring_pkg
// Shared types and helpers for the runtime-programmable delay line.
//   state_t        : fill state machine encoding (FILL, RUN)
//   clamp_del()    : maps a requested delay onto the legal range 1..max_del
//   max_del_legal(): parameter legality test (power of two, at least 2)
// Optional feature macro used by this block: DELAY_RING_CFG_ERR_EN.
package delay_ring_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Delay 0 behaves as 1; anything above max_del saturates at max_del.
  function automatic int unsigned clamp_del(input int unsigned del_cfg,
                                            input int unsigned max_del);
    if (del_cfg == 0) begin
      return 1;
    end else if (del_cfg > max_del) begin
      return max_del;
    end else begin
      return del_cfg;
    end
  endfunction

  // The ring index wraps by plain truncation, so the depth must be a power
  // of two; a depth of 1 would leave no room for the D=2 read-behind.
  function automatic bit max_del_legal(input int unsigned max_del);
    return (max_del >= 2) && ((max_del & (max_del - 1)) == 0);
  endfunction

endpackage

// File: rtl/delay_ring_if.sv
// delay_ring_if
// Signal bundle between a sample source/sink and the delay line.
//   din, din_valid : sample and qualifier, driven every cycle by the master
//   del_cfg        : requested delay in cycles (clamped inside the block)
//   dout, dout_valid : delayed sample and qualifier, zero while filling
//   busy           : high while the fill state machine is in FILL
//   fsm_state      : current fill state, for observation
//   cfg_err        : sticky out-of-range delay flag (only with DELAY_RING_CFG_ERR_EN)
// Handshake: there is no back-pressure. din/din_valid are consumed on every
// rising clk edge; dout/dout_valid are meaningful only while busy is low.
interface delay_ring_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_DEL = 16,
  parameter int DEL_W   = $clog2(MAX_DEL + 1)
);
  import delay_ring_pkg::*;

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic [DEL_W-1:0] del_cfg;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  state_t           fsm_state;
`ifdef DELAY_RING_CFG_ERR_EN
  logic             cfg_err;
`endif

  modport master (
    output din, din_valid, del_cfg,
    input  dout, dout_valid, busy, fsm_state
`ifdef DELAY_RING_CFG_ERR_EN
    , input cfg_err
`endif
  );

  modport slave (
    input  din, din_valid, del_cfg,
    output dout, dout_valid, busy, fsm_state
`ifdef DELAY_RING_CFG_ERR_EN
    , output cfg_err
`endif
  );

endinterface

// File: rtl/delay_ring_mem.sv
// delay_ring_mem
// Simple dual-port RAM: one synchronous write port, one registered read
// port, no reset (contents are masked by the owner until they are valid).
//   clk   : posedge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address, sampled on clk
//   rdata : registered read data
module delay_ring_mem #(
  parameter int DW    = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/delay_ring.sv
// delay_ring
// Runtime-programmable delay line on a circular buffer. A sample is written
// every cycle; the read index trails the write pointer so that dout carries
// din from exactly d_q cycles earlier. A fill state machine masks the output
// after every delay change until a full window at the new delay is present.
//   clk : posedge clock
//   rst : synchronous reset, active-high
//   bus : delay_ring_if slave (din, din_valid, del_cfg, dout, dout_valid,
//         busy, fsm_state, and cfg_err when DELAY_RING_CFG_ERR_EN is defined)
// Optional feature macro: DELAY_RING_CFG_ERR_EN adds the sticky cfg_err flag.
module delay_ring
  import delay_ring_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_DEL = 16,
  parameter int DEL_W   = $clog2(MAX_DEL + 1)
) (
  input  logic         clk,
  input  logic         rst,
  delay_ring_if.slave  bus
);

  localparam int AW = $clog2(MAX_DEL);
  localparam bit PARAM_OK = max_del_legal(MAX_DEL);

  always_ff @(posedge clk) begin
    assert (PARAM_OK) else $fatal(1, "delay_ring: MAX_DEL must be a power of two >= 2");
  end

  // ---------------------------------------------------------------------------
  // Fill state machine and pointers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [DEL_W-1:0] d_q, d_d;
  logic [DEL_W-1:0] cnt_q, cnt_d;
  logic [DEL_W-1:0] d_eff;
  logic [AW-1:0]    wp;
  logic [AW-1:0]    raddr;

  assign d_eff = DEL_W'(clamp_del(32'(bus.del_cfg), MAX_DEL));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    if (d_eff != d_q) begin
      // A new delay restarts the fill from either state.
      d_d     = d_eff;
      cnt_d   = '0;
      state_d = FILL;
    end else if (state_q == FILL) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == d_q - 1'b1) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      d_q     <= DEL_W'(1);
      wp      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      wp      <= wp + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Ring buffer
  // ---------------------------------------------------------------------------
  // The read at the end of cycle k feeds dout in cycle k+1, which must carry
  // the sample written at wp - (d_q - 1). For d_q >= 2 this never equals wp,
  // so read and write never collide; d_q == 1 uses the bypass register.
  logic [WIDTH:0] wdata;
  logic [WIDTH:0] rdata;
  logic [WIDTH:0] byp_q;
  logic [WIDTH:0] out_sel;

  assign wdata = {bus.din_valid, bus.din};
  assign raddr = wp - AW'(d_q - 1'b1);

  delay_ring_mem #(
    .DW    (WIDTH + 1),
    .DEPTH (MAX_DEL)
  ) u_mem (
    .clk   (clk),
    .we    (1'b1),
    .waddr (wp),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    byp_q <= wdata;
  end

  // Both data sources are flops; only the source select and the fill mask
  // sit between them and the pins. d_q is stable for any cycle spent in RUN,
  // so the select always matches the address used for the preceding read.
  assign out_sel        = (d_q == DEL_W'(1)) ? byp_q : rdata;
  assign bus.dout       = (state_q == RUN) ? out_sel[WIDTH-1:0] : '0;
  assign bus.dout_valid = (state_q == RUN) & out_sel[WIDTH];
  assign bus.busy       = (state_q == FILL);
  assign bus.fsm_state  = state_q;

`ifdef DELAY_RING_CFG_ERR_EN
  // Sticky record that a caller asked for a delay that had to be clamped.
  logic cfg_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else if ((bus.del_cfg == '0) || (bus.del_cfg > DEL_W'(MAX_DEL))) begin
      cfg_err_q <= 1'b1;
    end
  end

  assign bus.cfg_err = cfg_err_q;
`endif

endmodule
